// File: rtl/motion_frame_sequencer_pkg.sv
// Shared types and frame geometry for the motion-detect frame sequencer.
package motion_pkg;

  // Sequencer life cycle of one frame.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Datapath word and default frame geometry.
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = WORD_W / 8;
  localparam int IMG_W          = 720;
  localparam int IMG_H          = 540;
  localparam int BPP            = 3;

  // Number of datapath words needed to carry one frame of the given size.
  function automatic int words_per_frame(input int img_w = IMG_W,
                                         input int img_h = IMG_H,
                                         input int bpp   = BPP);
    return (img_w * img_h * bpp) / BYTES_PER_WORD;
  endfunction

endpackage

// File: rtl/motion_frame_sequencer_credit_counter.sv
// Saturating up/down credit counter guarding the highlight FIFO.
// Starts full (CREDITS), spends one credit per issued word and regains one
// per word the consumer pops. A return while already full is a protocol
// error: the count saturates and overflow is raised for that cycle.
module credit_counter #(
  parameter int CREDITS = 16,
  parameter int CRD_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CRD_W-1:0] credit_cnt,
  output logic             overflow
);

  localparam logic [CRD_W-1:0] MAX_CREDITS = CRD_W'(CREDITS);

  // A lone return against a full counter has nowhere to go.
  assign overflow = inc && !dec && (credit_cnt == MAX_CREDITS);

  // Credit count: simultaneous spend and return cancel out.
  // NOTE: registers use non-blocking assignment so every flop samples the
  // pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_cnt <= MAX_CREDITS;
    end else if (inc && !dec && !overflow) begin
      credit_cnt <= credit_cnt + 1'b1;
    end else if (dec && !inc && (credit_cnt != '0)) begin
      credit_cnt <= credit_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/motion_frame_sequencer.sv
// Frame-level scheduler for the motion-detect datapath.
// Pops the background and frame FIFOs in lockstep, strobes the pipeline one
// cycle later (FIFO read latency), limits words in flight with credits so the
// highlight FIFO cannot overflow, and reports frame completion.
module motion_frame_sequencer
  import motion_pkg::*;
#(
  parameter int WORDS_PER_FRAME = words_per_frame(),
  parameter int CNT_W           = 20,
  parameter int CREDITS         = 16,
  parameter int CRD_W           = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             bg_empty,
  input  logic             fr_empty,
  output logic             bg_rd_en,
  output logic             fr_rd_en,
  output logic             pipe_valid,
  input  logic             hl_wr_en,
  input  logic             hl_rd_en,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] written_cnt,
  output logic [CRD_W-1:0] credit_cnt,
  output logic             err
);

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_FRAME);
  localparam logic [CNT_W-1:0] PENULT    = CNT_W'(WORDS_PER_FRAME - 1);

  seq_state_t state;
  seq_state_t state_nxt;

  logic issue;
  logic in_frame;
  logic wr_accept;
  logic wr_reject;
  logic credit_ovf;
  logic frame_start;

  // Pop both FIFOs only when each has data, a credit is free, the frame is
  // not yet fully issued and no abort is pending.
  assign issue = (state == RUN) && !bg_empty && !fr_empty &&
                 (credit_cnt != '0) && (issued_cnt != LAST_WORD) && !abort;

  assign bg_rd_en = issue;
  assign fr_rd_en = issue;

  assign busy        = (state != IDLE);
  assign frame_start = (state == IDLE) && start;
  assign in_frame    = (state == RUN) || (state == DRAIN);

  // Writes count only inside a frame and below the frame size; an abort
  // cycle freezes the counters. Writes outside a frame or beyond the last
  // word are protocol errors.
  assign wr_accept = hl_wr_en && in_frame && (written_cnt != LAST_WORD) && !abort;
  assign wr_reject = hl_wr_en && (!in_frame || (written_cnt == LAST_WORD));

  credit_counter #(
    .CREDITS (CREDITS),
    .CRD_W   (CRD_W)
  ) u_credit_counter (
    .clk        (clk),
    .reset      (reset),
    .inc        (hl_rd_en),
    .dec        (issue),
    .credit_cnt (credit_cnt),
    .overflow   (credit_ovf)
  );

  // Next-state and completion strobe; abort overrides every transition.
  // NOTE: every variable gets a default before the case so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (issue && (issued_cnt == PENULT)) begin
          // Always pass through DRAIN, even if the last write lands now.
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if ((written_cnt == LAST_WORD) ||
                     (wr_accept && (written_cnt == PENULT))) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt  = IDLE;
        frame_done = !abort;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Pipeline strobe trails the pop by the FIFO read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pipe_valid <= 1'b0;
    else       pipe_valid <= issue;
  end

  // Per-frame word counters; cleared on start, held after completion/abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_cnt  <= '0;
      written_cnt <= '0;
    end else if (frame_start) begin
      issued_cnt  <= '0;
      written_cnt <= '0;
    end else begin
      if (issue)     issued_cnt  <= issued_cnt + 1'b1;
      if (wr_accept) written_cnt <= written_cnt + 1'b1;
    end
  end

  // Sticky protocol error: stray write or credit returned when none spent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        err <= 1'b0;
    else if (wr_reject || credit_ovf) err <= 1'b1;
  end

endmodule

// File: doc/motion_frame_sequencer.md
Name: motion_frame_sequencer

Overview:
- Frame-level scheduler for the motion-detect datapath.
- Pops background and frame FIFOs in lockstep, one 32-bit word each per cycle.
- Issues a valid strobe into the subtract/threshold/highlight pipeline.
- Uses credit-based flow control so the highlight FIFO never overflows; counts words per frame and reports frame completion.

Parameters:
- WORDS_PER_FRAME, 291600: 32-bit words per frame (720x540x3 bytes / 4).
- CNT_W, 20: width of the word counters; must hold WORDS_PER_FRAME.
- CREDITS, 16: max words in flight plus resident in the highlight FIFO. Set ≤ highlight FIFO depth.
- CRD_W, 5: credit counter width; must hold CREDITS.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begin a frame (honoured only in IDLE)
- abort  in  1  synchronous abandon of the current frame
- bg_empty  in  1  background FIFO empty
- fr_empty  in  1  frame FIFO empty
- bg_rd_en  out  1  background FIFO pop
- fr_rd_en  out  1  frame FIFO pop, always equal to bg_rd_en
- pipe_valid  out  1  registered bg_rd_en; qualifies FIFO dout entering pipeline
- hl_wr_en  in  1  pipeline writes one word into the highlight FIFO
- hl_rd_en  in  1  consumer pops one word from the highlight FIFO (returns a credit)
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse when all words of the frame are written
- issued_cnt  out  CNT_W  words popped this frame
- written_cnt  out  CNT_W  words written to the highlight FIFO this frame
- credit_cnt  out  CRD_W  available credits
- err  out  1  sticky protocol error

Behaviour:
- Reset (async, asserted): state=IDLE, and all of the following are 0: bg_rd_en, fr_rd_en, pipe_valid, frame_done, issued_cnt, written_cnt, err. credit_cnt=CREDITS. Outputs hold these values until reset deasserts.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 clears issued_cnt and written_cnt and moves to RUN next cycle.
  - start in any other state is ignored.
- issue (combinational, RUN only) = !bg_empty && !fr_empty && credit_cnt!=0 && issued_cnt!=WORDS_PER_FRAME && !abort.
  - bg_rd_en = fr_rd_en = issue. Zero latency from flags to rd_en.
  - pipe_valid is issue registered by one cycle, matching the FIFO's 1-cycle read latency.
- Credits, updated each cycle:
  - issue only: decrement.
  - hl_rd_en only: increment.
  - both: unchanged.
  - An increment while credit_cnt==CREDITS saturates and sets err.
  - Credits persist across frames and across abort; only reset restores them.
- issued_cnt increments on issue. The cycle it reaches WORDS_PER_FRAME, the FSM moves to DRAIN.
- written_cnt increments on hl_wr_en in RUN or DRAIN.
  - hl_wr_en when written_cnt==WORDS_PER_FRAME, or in IDLE/DONE: sets err and the count is not incremented.
- DRAIN: when written_cnt==WORDS_PER_FRAME (including via an increment that cycle), go to DONE next cycle.
- DONE: frame_done=1 for exactly that one cycle, then IDLE. Counters hold their final values until the next start.
- abort=1 in RUN/DRAIN/DONE: next state IDLE, no frame_done, issue suppressed in the abort cycle, counters hold.
  - Abort has priority over every other transition.
- Simultaneous final issue and final hl_wr_en in RUN cannot complete the frame. A minimum 1-cycle DRAIN residence is required.
- err clears only on reset.
- All counters are unsigned and never wrap. They are bounded by the rules above.

Decomposition:
- Shared package motion_pkg holds:
  - the state enum type seq_state_t {IDLE, RUN, DRAIN, DONE};
  - localparams WORD_W=32, BYTES_PER_WORD=4, and default frame geometry IMG_W=720, IMG_H=540, BPP=3;
  - the function words_per_frame().
- One natural sub-module: credit_counter, covering the saturating up/down counter, its overflow flag, and reset-to-CREDITS.
- The FSM and frame counters stay in the top.

Test Plan:
All tests run with WORDS_PER_FRAME=16, CREDITS=4, CNT_W=5, CRD_W=3.
- Reset check: reset held mid-RUN with issued_cnt=7 -> immediately busy=0, rd_en=0, issued_cnt=0, credit_cnt=4, err=0.
- Basic frame: start with both FIFOs full, consumer popping every cycle, pipeline hl_wr_en 3 cycles after pipe_valid -> 16 rd_en pulses, pipe_valid lags rd_en by exactly 1 cycle, frame_done one pulse after written_cnt=16, then busy=0.
- Backpressure: consumer never pops -> exactly 4 issues, credit_cnt=0, bg_rd_en stays 0. Pop one word -> exactly one more issue the following cycle.
- Empty skew: fr_empty=1 while bg_empty=0 -> neither rd_en asserts. Lockstep is held (bg_rd_en==fr_rd_en every cycle).
- Simultaneous events: issue and hl_rd_en in the same cycle -> credit_cnt unchanged. start during RUN -> ignored, counters unaffected.
- Abort/errors:
  - abort at issued_cnt=9 -> IDLE next cycle, no frame_done, credits retained; a subsequent start clears the counters.
  - A spurious hl_wr_en in IDLE -> err=1, sticky until reset.
